// File: rtl/fan_pwm_ramp_pkg.sv
// Shared definitions for the fan PWM ramp block: gear encodings, FSM state
// type and the gear-to-duty mapping helper.
package fan_pwm_ramp_pkg;

  localparam logic [1:0] FAN_OFF  = 2'b00;
  localparam logic [1:0] FAN_LOW  = 2'b01;
  localparam logic [1:0] FAN_MID  = 2'b10;
  localparam logic [1:0] FAN_HIGH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RAMP_DOWN = 3'd2,
    ST_HOLD      = 3'd3,
    ST_STOP      = 3'd4
  } fan_fsm_e;

  function automatic int unsigned gear_duty(input logic [1:0] gear,
                                            input int unsigned lo,
                                            input int unsigned mid,
                                            input int unsigned hi);
    case (gear)
      FAN_LOW:  return lo;
      FAN_MID:  return mid;
      FAN_HIGH: return hi;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/fan_pwm_ramp_pwm_core.sv
// pwm_core: free-running PWM period counter and registered duty compare.
//  clk, reset : clock, asynchronous active-high reset
//  duty       : duty that will be applied in the cycle after this edge
//  pwm_out    : registered drive, high while cnt < applied duty
//  boundary   : high on the last cycle of each PWM period (cnt == PERIOD-1)
module pwm_core #(
  parameter int unsigned PERIOD = 10,
  parameter int unsigned DW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] duty,
  output logic          pwm_out,
  output logic          boundary
);

  localparam int unsigned CW = $clog2(PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    boundary = (cnt_q == CW'(PERIOD - 1));
    cnt_d    = boundary ? '0 : cnt_q + CW'(1);
    // Compare the next count against the next duty so the registered output
    // lines up with the count/duty pair held during the following cycle.
    pwm_d    = (DW'(cnt_d) < duty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/fan_pwm_ramp.sv
// fan_pwm_ramp: turns the 2-bit fan gear into a PWM motor drive with a
// soft-start/soft-stop duty ramp and a hard cut-off on battery exhaustion.
//  clk, reset    : clock, asynchronous active-high reset
//  fan_state     : gear 00 off, 01 low, 10 mid, 11 high
//  battery_empty : level, forces immediate stop while high
//  pwm_out       : registered motor drive
//  duty_now      : duty applied in the current PWM period
//  ramp_busy     : duty_now differs from the gear target (not stopped)
//  at_target     : duty_now equals the gear target (not stopped)
//  stopped       : in STOP state
module fan_pwm_ramp
  import fan_pwm_ramp_pkg::*;
#(
  parameter int unsigned PERIOD       = 10,
  parameter int unsigned DUTY_LOW     = 3,
  parameter int unsigned DUTY_MID     = 6,
  parameter int unsigned DUTY_HIGH    = 10,
  parameter int unsigned RAMP_PERIODS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   fan_state,
  input  logic                         battery_empty,
  output logic                         pwm_out,
  output logic [$clog2(PERIOD+1)-1:0]  duty_now,
  output logic                         ramp_busy,
  output logic                         at_target,
  output logic                         stopped
);

  localparam int unsigned DW = $clog2(PERIOD + 1);
  localparam int unsigned SW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  if (PERIOD < 2 || RAMP_PERIODS < 1 ||
      DUTY_LOW > PERIOD || DUTY_MID > PERIOD || DUTY_HIGH > PERIOD) begin : g_bad_param
    $error("fan_pwm_ramp: illegal parameter set");
  end

  fan_fsm_e      state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [SW-1:0] step_q, step_d;
  logic [SW-1:0] step_eff;
  logic [DW-1:0] target;
  logic [DW-1:0] duty_step;
  logic          boundary;
  logic          go_up;

  always_comb begin
    target    = DW'(gear_duty(fan_state, DUTY_LOW, DUTY_MID, DUTY_HIGH));
    state_d   = state_q;
    duty_d    = duty_q;
    step_d    = step_q;
    go_up     = (target > duty_q);
    step_eff  = '0;
    duty_step = duty_q;

    if (battery_empty) begin
      state_d = ST_STOP;
      duty_d  = '0;
      step_d  = '0;
    end else if (state_q == ST_STOP) begin
      state_d = ST_IDLE;
    end else if (boundary) begin
      if (target == duty_q) begin
        state_d = (duty_q == '0) ? ST_IDLE : ST_HOLD;
        step_d  = '0;
      end else begin
        // The boundary that starts a ramp (from IDLE/HOLD or a reversal)
        // counts as the first of the RAMP_PERIODS boundaries of that step.
        if ((go_up && state_q == ST_RAMP_UP) || (!go_up && state_q == ST_RAMP_DOWN))
          step_eff = step_q;
        if (step_eff == SW'(RAMP_PERIODS - 1)) begin
          if (go_up && duty_q < DW'(PERIOD))
            duty_step = duty_q + DW'(1);
          else if (!go_up && duty_q > '0)
            duty_step = duty_q - DW'(1);
          duty_d = duty_step;
          step_d = '0;
          if (duty_step == target)
            state_d = (target == '0) ? ST_IDLE : ST_HOLD;
          else
            state_d = go_up ? ST_RAMP_UP : ST_RAMP_DOWN;
        end else begin
          step_d  = step_eff + SW'(1);
          state_d = go_up ? ST_RAMP_UP : ST_RAMP_DOWN;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      step_q  <= step_d;
    end
  end

  pwm_core #(
    .PERIOD (PERIOD),
    .DW     (DW)
  ) u_pwm_core (
    .clk      (clk),
    .reset    (reset),
    .duty     (duty_d),
    .pwm_out  (pwm_out),
    .boundary (boundary)
  );

  assign duty_now  = duty_q;
  assign stopped   = (state_q == ST_STOP);
  assign ramp_busy = !stopped && (duty_q != target);
  assign at_target = !stopped && (duty_q == target);

endmodule

// File: tb/tb_fan_pwm_ramp.sv
module tb_fan_pwm_ramp;

  localparam int P  = 10;
  localparam int RP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] fan_state;
  logic       battery_empty;
  logic       pwm_out;
  logic [3:0] duty_now;
  logic       ramp_busy;
  logic       at_target;
  logic       stopped;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: period position, applied duty, ramp direction,
  // boundaries elapsed in the current step, stop flag.
  int m_cnt = 0, m_duty = 0, m_dir = 0, m_elapsed = 0, m_stop = 0;

  fan_pwm_ramp #(
    .PERIOD       (10),
    .DUTY_LOW     (3),
    .DUTY_MID     (6),
    .DUTY_HIGH    (10),
    .RAMP_PERIODS (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fan_state     (fan_state),
    .battery_empty (battery_empty),
    .pwm_out       (pwm_out),
    .duty_now      (duty_now),
    .ramp_busy     (ramp_busy),
    .at_target     (at_target),
    .stopped       (stopped)
  );

  always #5 clk = ~clk;

  function automatic int tgt_of(input logic [1:0] g);
    case (g)
      2'b01:   return 3;
      2'b10:   return 6;
      2'b11:   return 10;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s @%0t: wait bound expired", name, $time);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_duty = 0; m_dir = 0; m_elapsed = 0; m_stop = 0;
    end else begin
      int t, d;
      t = tgt_of(fan_state);
      if (battery_empty) begin
        m_stop = 1; m_duty = 0; m_dir = 0; m_elapsed = 0;
      end else if (m_stop != 0) begin
        m_stop = 0;
      end else if (m_cnt == P - 1) begin
        if (t == m_duty) begin
          m_dir = 0; m_elapsed = 0;
        end else begin
          d = (t > m_duty) ? 1 : -1;
          if (d != m_dir) begin
            m_dir = d; m_elapsed = 0;
          end
          m_elapsed++;
          if (m_elapsed == RP) begin
            m_duty += d;
            m_elapsed = 0;
            if (m_duty == t) m_dir = 0;
          end
        end
      end
      m_cnt = (m_cnt + 1) % P;
    end
  end

  always @(posedge clk) begin
    int t;
    #1;
    t = tgt_of(fan_state);
    check("pwm_out",   int'(pwm_out),   (m_cnt < m_duty) ? 1 : 0);
    check("duty_now",  int'(duty_now),  m_duty);
    check("stopped",   int'(stopped),   m_stop);
    check("ramp_busy", int'(ramp_busy), (m_stop == 0 && m_duty != t) ? 1 : 0);
    check("at_target", int'(at_target), (m_stop == 0 && m_duty == t) ? 1 : 0);
  end

  initial begin
    int exp1 [7] = '{0, 0, 1, 1, 2, 2, 3};
    int exp_pwm [3] = '{1, 1, 0};
    int guard;

    reset = 1'b1; fan_state = 2'b01; battery_empty = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: soft start to gear 01
    check("t1_duty_p0", int'(duty_now), exp1[0]);
    for (int p = 1; p <= 6; p++) begin
      repeat (10) @(negedge clk);
      check($sformatf("t1_duty_p%0d", p), int'(duty_now), exp1[p]);
    end
    check("t1_at_target", int'(at_target), 1);
    check("t1_pwm_c0", int'(pwm_out), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t1_pwm_c%0d", c + 1), int'(pwm_out), exp_pwm[c]);
    end

    // 2: climb 3 -> 10
    fan_state = 2'b11;
    repeat (37) @(negedge clk);
    check("t2_duty_mid", int'(duty_now), 5);
    check("t2_busy", int'(ramp_busy), 1);
    repeat (100) @(negedge clk);
    check("t2_duty_top", int'(duty_now), 10);
    for (int c = 0; c < P; c++) begin
      @(negedge clk);
      check("t2_pwm_full", int'(pwm_out), 1);
    end

    // 3: down to 6, start back up, reverse to off
    fan_state = 2'b10;
    guard = 0;
    while (!(m_duty == 6 && m_dir == 0) && guard < 300) begin @(negedge clk); guard++; end
    if (guard >= 300) timeout("t3_reach6");
    fan_state = 2'b11;
    guard = 0;
    while (!(m_duty == 6 && m_dir == 1) && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) timeout("t3_rampup");
    fan_state = 2'b00;
    repeat (160) @(negedge clk);
    check("t3_duty", int'(duty_now), 0);
    check("t3_at_target", int'(at_target), 1);
    for (int c = 0; c < P; c++) begin
      @(negedge clk);
      check("t3_pwm_off", int'(pwm_out), 0);
    end

    // 4: battery cut mid-period
    fan_state = 2'b10;
    guard = 0;
    while (!(m_duty == 6 && m_dir == 0 && m_cnt == 1) && guard < 300) begin @(negedge clk); guard++; end
    if (guard >= 300) timeout("t4_reach6");
    check("t4_pwm_before", int'(pwm_out), 1);
    battery_empty = 1'b1;
    @(negedge clk);
    check("t4_pwm_cut", int'(pwm_out), 0);
    check("t4_stopped", int'(stopped), 1);
    check("t4_duty", int'(duty_now), 0);
    repeat (5) @(negedge clk);
    battery_empty = 1'b0;
    @(negedge clk);
    check("t4_released", int'(stopped), 0);
    repeat (200) @(negedge clk);
    check("t4_duty_rampback", int'(duty_now), 6);

    // 5: gear glitch between boundaries
    fan_state = 2'b01;
    guard = 0;
    while (!(m_duty == 3 && m_dir == 0 && m_cnt == 2) && guard < 300) begin @(negedge clk); guard++; end
    if (guard >= 300) timeout("t5_reach3");
    fan_state = 2'b10;
    repeat (3) @(negedge clk);
    fan_state = 2'b01;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t5_duty_hold", int'(duty_now), 3);
    end

    // 6: async reset mid ramp-up, counter restarts
    fan_state = 2'b11;
    guard = 0;
    while (!(m_dir == 1 && m_cnt == 4) && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) timeout("t6_ramp");
    #2;
    reset = 1'b1; fan_state = 2'b00;
    #1;
    check("t6_pwm", int'(pwm_out), 0);
    check("t6_duty", int'(duty_now), 0);
    check("t6_stopped", int'(stopped), 0);
    check("t6_busy", int'(ramp_busy), 0);
    check("t6_at_target", int'(at_target), 1);
    fan_state = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    repeat (19) @(negedge clk);
    check("t6_duty_k19", int'(duty_now), 0);
    @(negedge clk);
    check("t6_duty_k20", int'(duty_now), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) fan_state = 2'($urandom_range(0, 3));
      if (!battery_empty && $urandom_range(0, 299) == 0) battery_empty = 1'b1;
      else if (battery_empty && $urandom_range(0, 7) == 0) battery_empty = 1'b0;
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    battery_empty = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
